// File: rtl/latch_bank_pkg.sv
// Shared mode encoding and write-strobe decode for the latch_bank channels.
package latch_bank_pkg;

  typedef enum logic [1:0] {
    MODE_TRANSP     = 2'b00,
    MODE_EDGE       = 2'b01,
    MODE_FREEZE     = 2'b10,
    MODE_FREEZE_ALT = 2'b11
  } mode_e;

  // Write strobe for one channel given the global mode and its gate history.
  function automatic logic wr_strobe(input logic [1:0] mode,
                                     input logic       gate,
                                     input logic       gate_q);
    logic wr;
    wr = 1'b0;
    case (mode_e'(mode))
      MODE_TRANSP: wr = gate;
      MODE_EDGE:   wr = gate & ~gate_q;
      default:     wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/latch_bank_if.sv
// Control/data bus of the latch bank; clk and clr_n stay outside as plain ports.
interface latch_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 4
);
  logic [1:0]           mode;
  logic [CH-1:0]        gate;
  logic [CH*WIDTH-1:0]  d;
  logic [CH-1:0]        clr_ch;
  logic [CH-1:0]        ack;
  logic [CH*WIDTH-1:0]  q;
  logic [CH-1:0]        changed;
  logic [CH*CNT_W-1:0]  upd_cnt;

  modport master (
    output mode, gate, d, clr_ch, ack,
    input  q, changed, upd_cnt
  );

  modport slave (
    input  mode, gate, d, clr_ch, ack,
    output q, changed, upd_cnt
  );
endinterface

// File: rtl/latch_bank_ch.sv
// One storage channel: gate history, stored value, sticky changed flag and
// saturating update counter, with priority clr_n > clr_ch > write.
module latch_bank_ch
  import latch_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [1:0]       mode,
  input  logic             gate,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ch,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             changed,
  output logic [CNT_W-1:0] upd_cnt
);

  logic gate_q;
  logic wr;
  logic wr_diff;

  always_comb begin
    wr      = wr_strobe(mode, gate, gate_q);
    wr_diff = wr && (d != q);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      gate_q  <= 1'b0;
      q       <= '0;
      changed <= 1'b0;
      upd_cnt <= '0;
    end else begin
      // gate history runs regardless of mode or soft clear
      gate_q <= gate;
      if (clr_ch) begin
        q       <= '0;
        changed <= 1'b0;
        upd_cnt <= '0;
      end else begin
        if (wr)
          q <= d;
        if (wr_diff) begin
          changed <= 1'b1;
          if (upd_cnt != '1)
            upd_cnt <= upd_cnt + 1'b1;
        end else if (ack) begin
          changed <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/latch_bank.sv
// Bank of CH independent latch channels; slices the bus and shares mode/clk/clr_n.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  latch_bank_if.slave  bus
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    latch_bank_ch #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .clr_n   (clr_n),
      .mode    (bus.mode),
      .gate    (bus.gate[i]),
      .d       (bus.d[i*WIDTH +: WIDTH]),
      .clr_ch  (bus.clr_ch[i]),
      .ack     (bus.ack[i]),
      .q       (bus.q[i*WIDTH +: WIDTH]),
      .changed (bus.changed[i]),
      .upd_cnt (bus.upd_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_latch_bank.sv
// Directed scoreboard bench for latch_bank (WIDTH=8, CH=4, CNT_W=2).
module tb_latch_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CH    = 4;
  localparam int unsigned CNT_W = 2;

  localparam logic [1:0] M_TRANSP = 2'b00;
  localparam logic [1:0] M_EDGE   = 2'b01;
  localparam logic [1:0] M_FRZ    = 2'b10;
  localparam logic [1:0] M_FRZ11  = 2'b11;

  logic clk;
  logic clr_n;
  int   cyc;

  latch_bank_if #(.WIDTH(WIDTH), .CH(CH), .CNT_W(CNT_W)) bus ();

  latch_bank #(.WIDTH(WIDTH), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         ch;
    logic [7:0] q;
    logic       chg;
    logic [1:0] cnt;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected state of one channel after the upcoming clock edge.
  task automatic exp_ch(input int ch, input logic [7:0] q, input logic chg,
                        input logic [1:0] cnt, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.ch   = ch;
    e.q    = q;
    e.chg  = chg;
    e.cnt  = cnt;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] m, input logic [3:0] g,
                     input logic [3:0] c, input logic [3:0] a);
    bus.mode   = m;
    bus.gate   = g;
    bus.clr_ch = c;
    bus.ack    = a;
  endtask

  task automatic set_d(input int ch, input logic [7:0] v);
    bus.d[ch*WIDTH +: WIDTH] = v;
  endtask

  exp_t       m_e;
  logic [7:0] a_q;
  logic       a_chg;
  logic [1:0] a_cnt;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e   = sb.pop_front();
      a_q   = bus.q[m_e.ch*WIDTH +: WIDTH];
      a_chg = bus.changed[m_e.ch];
      a_cnt = bus.upd_cnt[m_e.ch*CNT_W +: CNT_W];
      n_cmp++;
      if (m_e.cyc != cyc || a_q !== m_e.q || a_chg !== m_e.chg || a_cnt !== m_e.cnt) begin
        n_bad++;
        $display("FAIL %s ch%0d: got q=%h changed=%b upd_cnt=%0d, required q=%h changed=%b upd_cnt=%0d (cycle %0d/%0d)",
                 m_e.name, m_e.ch, a_q, a_chg, a_cnt, m_e.q, m_e.chg, m_e.cnt, cyc, m_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    bus.mode   = M_TRANSP;
    bus.gate   = 4'($urandom);
    bus.d      = $urandom;
    bus.clr_ch = '0;
    bus.ack    = '0;
    tick();

    // second reset cycle: park ch0 gate high in EDGE mode for release
    drv(M_EDGE, 4'b0001, 4'b0000, 4'b0000);
    bus.d = $urandom;
    set_d(0, 8'h3C);
    for (int i = 0; i < 4; i++) exp_ch(i, 8'h00, 1'b0, 2'd0, "reset");
    tick();

    clr_n = 1'b1;
    exp_ch(0, 8'h3C, 1'b1, 2'd1, "edge_after_reset");
    tick();
    set_d(0, 8'h77);
    exp_ch(0, 8'h3C, 1'b1, 2'd1, "edge_hold_high");
    tick();
    drv(M_TRANSP, 4'b0000, 4'b0001, 4'b0000);
    exp_ch(0, 8'h00, 1'b0, 2'd0, "clr_ch0");
    tick();

    // TRANSP on ch0
    drv(M_TRANSP, 4'b0001, 4'b0000, 4'b0000);
    set_d(0, 8'h11); exp_ch(0, 8'h11, 1'b1, 2'd1, "transp_11"); tick();
    set_d(0, 8'h22); exp_ch(0, 8'h22, 1'b1, 2'd2, "transp_22"); tick();
    set_d(0, 8'h22); exp_ch(0, 8'h22, 1'b1, 2'd2, "transp_same"); tick();
    set_d(0, 8'h33); exp_ch(0, 8'h33, 1'b1, 2'd3, "transp_33"); tick();
    drv(M_TRANSP, 4'b0000, 4'b0000, 4'b0000);
    set_d(0, 8'h44); exp_ch(0, 8'h33, 1'b1, 2'd3, "transp_hold"); tick();

    // EDGE on ch1
    drv(M_EDGE, 4'b0000, 4'b0000, 4'b0000);
    set_d(1, 8'hA5); exp_ch(1, 8'h00, 1'b0, 2'd0, "edge_low"); tick();
    drv(M_EDGE, 4'b0010, 4'b0000, 4'b0000);
    exp_ch(1, 8'hA5, 1'b1, 2'd1, "edge_rise1"); tick();
    set_d(1, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      exp_ch(1, 8'hA5, 1'b1, 2'd1, "edge_held");
      tick();
    end
    drv(M_EDGE, 4'b0000, 4'b0000, 4'b0000);
    exp_ch(1, 8'hA5, 1'b1, 2'd1, "edge_fall"); tick();
    drv(M_EDGE, 4'b0010, 4'b0000, 4'b0000);
    exp_ch(1, 8'h5A, 1'b1, 2'd2, "edge_rise2"); tick();

    // FREEZE and same-cycle events on ch2
    drv(M_TRANSP, 4'b0100, 4'b0000, 4'b0000);
    set_d(2, 8'h10); exp_ch(2, 8'h10, 1'b1, 2'd1, "pre_freeze"); tick();
    set_d(2, 8'h99);
    drv(M_FRZ, 4'b0000, 4'b0000, 4'b0000);   exp_ch(2, 8'h10, 1'b1, 2'd1, "freeze_lo"); tick();
    drv(M_FRZ, 4'b0100, 4'b0000, 4'b0000);   exp_ch(2, 8'h10, 1'b1, 2'd1, "freeze_hi"); tick();
    drv(M_FRZ11, 4'b0000, 4'b0000, 4'b0000); exp_ch(2, 8'h10, 1'b1, 2'd1, "freeze11_lo"); tick();
    drv(M_FRZ11, 4'b0100, 4'b0000, 4'b0000); exp_ch(2, 8'h10, 1'b1, 2'd1, "freeze11_hi"); tick();
    drv(M_FRZ, 4'b0000, 4'b0000, 4'b0100);   exp_ch(2, 8'h10, 1'b0, 2'd1, "freeze_ack"); tick();
    drv(M_TRANSP, 4'b0100, 4'b0000, 4'b0100);
    set_d(2, 8'h20); exp_ch(2, 8'h20, 1'b1, 2'd2, "ack_vs_write"); tick();
    exp_ch(2, 8'h20, 1'b0, 2'd2, "ack_same_value"); tick();
    drv(M_TRANSP, 4'b0100, 4'b0100, 4'b0000);
    set_d(2, 8'h55); exp_ch(2, 8'h00, 1'b0, 2'd0, "clr_vs_write"); tick();

    // Counter saturation on ch3
    drv(M_TRANSP, 4'b1000, 4'b0000, 4'b0000);
    for (int i = 1; i <= 5; i++) begin
      set_d(3, 8'(i));
      exp_ch(3, 8'(i), 1'b1, (i > 3) ? 2'd3 : 2'(i), "saturate");
      tick();
    end
    drv(M_TRANSP, 4'b0000, 4'b0000, 4'b1000);
    exp_ch(3, 8'h05, 1'b0, 2'd3, "ack_keeps_cnt"); tick();
    drv(M_TRANSP, 4'b1000, 4'b0000, 4'b0000);
    set_d(3, 8'h06); exp_ch(3, 8'h06, 1'b1, 2'd3, "transp_06"); tick();
    drv(M_EDGE, 4'b1000, 4'b0000, 4'b0000);
    set_d(3, 8'h07); exp_ch(3, 8'h06, 1'b1, 2'd3, "transp_to_edge_high"); tick();

    // Channel isolation
    drv(M_TRANSP, 4'b1111, 4'b0100, 4'b0000);
    set_d(0, 8'hA0); set_d(1, 8'hA1); set_d(2, 8'hA2); set_d(3, 8'hA3);
    exp_ch(0, 8'hA0, 1'b1, 2'd3, "iso_ch0");
    exp_ch(1, 8'hA1, 1'b1, 2'd3, "iso_ch1");
    exp_ch(2, 8'h00, 1'b0, 2'd0, "iso_ch2_clr");
    exp_ch(3, 8'hA3, 1'b1, 2'd3, "iso_ch3");
    tick();
    drv(M_TRANSP, 4'b1111, 4'b0000, 4'b0000);
    exp_ch(2, 8'hA2, 1'b1, 2'd1, "iso_ch2_after");
    exp_ch(0, 8'hA0, 1'b1, 2'd3, "iso_ch0_same");
    tick();

    tick();
    tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latch_bank.md
# latch_bank

Parametrised, fully synchronous successor to the single-bit D-latch primitive: a bank of CH independent WIDTH-bit storage channels sharing one clock and one global reset. Each channel captures its data either level-sensitively (transparent while its gate is high) or on the rising edge of its gate, selected by a global mode. Each channel also has a freeze mode, a per-channel soft clear, a sticky "changed" flag with acknowledge, and a saturating update counter. It sits between raw control/status inputs and software-visible registers, where the bare latch cannot be used.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- CH, 4, number of channels (≥1)
- CNT_W, 4, per-channel update-counter width (≥1)

- clk  in  1  single clock, all state on rising edge
- clr_n  in  1  reset, synchronous, active-low
- mode  in  2  global mode: 00 TRANSP, 01 EDGE, 10 FREEZE, 11 FREEZE
- gate  in  CH  per-channel gate/enable
- d  in  CH*WIDTH  channel data, channel i at [i*WIDTH +: WIDTH]
- clr_ch  in  CH  per-channel soft clear, active-high
- ack  in  CH  per-channel clear of changed flag
- q  out  CH*WIDTH  stored channel data
- changed  out  CH  sticky flag: q written with a different value since last ack/clear
- upd_cnt  out  CH*CNT_W  saturating count of value-changing writes, channel i at [i*CNT_W +: CNT_W]

## Operation
- Reset (clr_n=0 at a clk edge): q=0, changed=0, upd_cnt=0, internal gate_q=0 for all channels. No other input is honoured in that cycle.
- gate_q[i] registers gate[i] every cycle in all modes, so edge detection stays valid across mode switches.
- Write strobe wr[i]:
  - TRANSP: gate[i].
  - EDGE: gate[i] & ~gate_q[i].
  - FREEZE / 11: 0.
- Per channel, priority is clr_n > clr_ch > write:
  - clr_ch[i]=1: q=0, changed=0, upd_cnt=0. A write in the same cycle is discarded.
  - wr[i]=1: q<=d slice.
  - If wr[i]=1 and the d slice ≠ current q: changed<=1 and upd_cnt increments, saturating at 2^CNT_W−1 (never wraps).
  - If wr[i]=1 and the d slice equals current q: no flag or counter effect.
- ack[i]=1 clears changed[i] unless a value-changing write occurs in the same cycle, in which case set wins (changed stays 1).
- ack has no effect on q or upd_cnt.
- Channels are fully independent. Only mode, clk and clr_n are shared.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Write latency is 1 cycle: d sampled at edge N appears on q after edge N. changed and upd_cnt update at the same edge.
- TRANSP: q follows d with 1-cycle delay while the gate is held high, and holds its value the first cycle the gate is low.
- EDGE: exactly one capture per low→high gate transition. Holding the gate high captures nothing further.
  - A gate already high when leaving reset counts as an edge on the first cycle after reset, because gate_q=0.
- A mode change is effective at the edge where it is sampled.
  - Switching TRANSP→EDGE while the gate is high produces no capture, because gate_q is already 1.
- FREEZE: q, changed and upd_cnt are stable, except that clr_ch and ack still act.

## Structure
- latch_bank_pkg: mode encoding constants (MODE_TRANSP=2'b00, MODE_EDGE=2'b01, MODE_FREEZE=2'b10) and the write-strobe decode function.
- Sub-module latch_bank_ch: one channel, holding gate_q, q, changed and upd_cnt, with its priority logic. It is instantiated CH times via generate. The top level only slices buses and distributes mode/clk/clr_n.

## Test plan
- Reset: drive random d/gate, assert clr_n=0 for 2 cycles → q=0, changed=0, upd_cnt=0 on all channels. With gate[0]=1 held through reset release in EDGE mode → q0 captures d0 one cycle after release.
- TRANSP, WIDTH=8: ch0 gate=1, d0=0x11, 0x22, 0x22, 0x33 on successive cycles → q0 lags one cycle each, upd_cnt0=3, changed0=1. Drop gate → q0 holds 0x33.
- EDGE: ch1 d1=0xA5, gate pulses 0→1 and stays high 4 cycles while d1 changes to 0x5A → q1=0xA5 only. A second rising edge → q1=0x5A, upd_cnt1=2.
- FREEZE + simultaneous events:
  - mode=10, gate toggling, new d → q unchanged.
  - Back in TRANSP, same-cycle ack[2] and a value-changing write → changed2=1.
  - Same-cycle clr_ch[2] and write → q2=0, upd_cnt2=0, changed2=0.
- Saturation, CNT_W=2: ch3 in TRANSP, 5 value-changing writes → upd_cnt3 goes 1,2,3,3,3. Then ack[3] → changed3=0 with upd_cnt3 still 3.
- Channel isolation: clr_ch=4'b0100 while all channels write in TRANSP → only ch2 zeroes. The other channels update normally.
